// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared definitions for the SRAM-like slave.
//   - Transfer size encodings (SIZE_BYTE / SIZE_HALF / SIZE_WORD).
//   - Controller state encoding.
// The WAIT state exists only when SRAM_LIKE_SLAVE_DELAY_EN is defined.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAM  = 2'd1,
        RESP = 2'd2
`ifdef SRAM_LIKE_SLAVE_DELAY_EN
        ,
        WAIT = 2'd3
`endif
    } sl_state_t;

endpackage

// File: rtl/sl_byte_enable.sv
// sl_byte_enable: decodes transfer size and the low address bits into
// per-byte-lane write enables and a misalignment flag.
// Ports:
//   size       in  2  transfer size (SIZE_BYTE/SIZE_HALF/SIZE_WORD; 11 = word)
//   addr_lo    in  2  byte address bits [1:0]
//   we         out 4  byte-lane enables for the 32-bit word
//   misaligned out 1  access is not naturally aligned for its size
module sl_byte_enable
    import sram_like_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] we,
    output logic       misaligned
);

    always_comb begin
        we         = 4'b1111;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                we = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                we         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            default: begin
                // SIZE_WORD and the unused 2'b11 encoding both act as a word
                we         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave: single-outstanding SRAM-like bus slave in front of a
// synchronous SRAM with one cycle of read latency.
//
// Optional feature: define SRAM_LIKE_SLAVE_DELAY_EN to add parameter DELAY,
// a WAIT state and a down-counter inserting DELAY extra cycles between the
// RAM read capture and data_ok. Without it latency is fixed at 2 cycles.
//
// Ports:
//   clk         in  1   clock
//   areset      in  1   synchronous reset, active low
//   sl_req      in  1   master request valid
//   sl_wr       in  1   1 = write, 0 = read
//   sl_size     in  2   00 byte, 01 half, 10 word
//   sl_addr     in  32  byte address
//   sl_wdata    in  32  lane-aligned write data
//   sl_rdata    out 32  read data, valid with sl_data_ok, held otherwise
//   sl_addr_ok  out 1   request accepted this cycle
//   sl_data_ok  out 1   transaction complete this cycle
//   ram_en      out 1   SRAM enable
//   ram_we      out 4   SRAM byte write enables
//   ram_addr    out 32  SRAM word-aligned address
//   ram_wdata   out 32  SRAM write data
//   ram_rdata   in  32  SRAM read data (one cycle after ram_en)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; a request is accepted combinationally (addr_ok)
// RAM   | SRAM access in flight; ram_rdata captured at end of cycle
// WAIT  | extra DELAY cycles before response (delay build only)
// RESP  | data_ok asserted for exactly this cycle
module sram_like_slave
    import sram_like_pkg::*;
`ifdef SRAM_LIKE_SLAVE_DELAY_EN
#(
    parameter int unsigned DELAY = 0
)
`endif
(
    input  logic        clk,
    input  logic        areset,
    input  logic        sl_req,
    input  logic        sl_wr,
    input  logic [1:0]  sl_size,
    input  logic [31:0] sl_addr,
    input  logic [31:0] sl_wdata,
    output logic [31:0] sl_rdata,
    output logic        sl_addr_ok,
    output logic        sl_data_ok,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    sl_state_t   state_q;
    sl_state_t   state_d;
    logic [31:0] rdata_q;
    logic        zero_q;
    logic [3:0]  be;
    logic        mis;
    logic        accept;

`ifdef SRAM_LIKE_SLAVE_DELAY_EN
    // Width guarded so DELAY=0 still yields a legal 1-bit counter.
    localparam int unsigned CNT_W    = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam int unsigned DELAY_M1 = (DELAY > 0) ? DELAY - 1 : 0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
`endif

    sl_byte_enable u_byte_enable (
        .size       (sl_size),
        .addr_lo    (sl_addr[1:0]),
        .we         (be),
        .misaligned (mis)
    );

    // Reset gates every handshake so nothing escapes while areset is low.
    assign accept = areset && (state_q == IDLE) && sl_req;

    always_comb begin
        state_d = state_q;
`ifdef SRAM_LIKE_SLAVE_DELAY_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RAM;
                end
            end
            RAM: begin
`ifdef SRAM_LIKE_SLAVE_DELAY_EN
                if (DELAY > 0) begin
                    state_d = WAIT;
                    // Terminal count at zero gives exactly DELAY WAIT cycles.
                    cnt_d   = CNT_W'(DELAY_M1);
                end else begin
                    state_d = RESP;
                end
`else
                state_d = RESP;
`endif
            end
`ifdef SRAM_LIKE_SLAVE_DELAY_EN
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sl_addr_ok = accept;
        sl_data_ok = areset && (state_q == RESP);
        // Misaligned requests are acknowledged but never reach the SRAM.
        ram_en     = accept && !mis;
        ram_we     = (ram_en && sl_wr) ? be : 4'b0000;
        ram_addr   = ram_en ? {sl_addr[31:2], 2'b00} : 32'h0;
        ram_wdata  = ram_en ? sl_wdata : 32'h0;
        sl_rdata   = areset ? rdata_q : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Writes and misaligned accesses complete with zero data.
                zero_q <= sl_wr | mis;
            end
            if (state_q == RAM) begin
                rdata_q <= zero_q ? 32'h0 : ram_rdata;
            end
        end
    end

`ifdef SRAM_LIKE_SLAVE_DELAY_EN
    always_ff @(posedge clk) begin
        if (!areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: self-checking bench for sram_like_slave.
// A behavioural SRAM drives ram_rdata; an independent reference memory and a
// transaction-level model predict every output each cycle. Directed cases pin
// the model with literal values, then randomized traffic with sporadic resets
// runs against the same model.
`timescale 1ns/1ps
module tb_sram_like_slave;

`ifdef SRAM_LIKE_SLAVE_DELAY_EN
   localparam int DLY = 3;
`else
   localparam int DLY = 0;
`endif

   logic        clk = 1'b0;
   logic        areset = 1'b0;
   logic        sl_req = 1'b0;
   logic        sl_wr = 1'b0;
   logic [1:0]  sl_size = 2'b00;
   logic [31:0] sl_addr = 32'h0;
   logic [31:0] sl_wdata = 32'h0;
   logic [31:0] sl_rdata;
   logic        sl_addr_ok;
   logic        sl_data_ok;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;

   always #5 clk = ~clk;

`ifdef SRAM_LIKE_SLAVE_DELAY_EN
   sram_like_slave #(.DELAY(DLY)) dut (
      .clk        (clk),
      .areset     (areset),
      .sl_req     (sl_req),
      .sl_wr      (sl_wr),
      .sl_size    (sl_size),
      .sl_addr    (sl_addr),
      .sl_wdata   (sl_wdata),
      .sl_rdata   (sl_rdata),
      .sl_addr_ok (sl_addr_ok),
      .sl_data_ok (sl_data_ok),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );
`else
   sram_like_slave dut (
      .clk        (clk),
      .areset     (areset),
      .sl_req     (sl_req),
      .sl_wr      (sl_wr),
      .sl_size    (sl_size),
      .sl_addr    (sl_addr),
      .sl_wdata   (sl_wdata),
      .sl_rdata   (sl_rdata),
      .sl_addr_ok (sl_addr_ok),
      .sl_data_ok (sl_data_ok),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural synchronous SRAM, read-before-write, 256 words aliased.
   logic [31:0] ram_mem [0:255];
   logic [31:0] ref_mem [0:255];

   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= ram_mem[ram_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: actual %h required %h", nm, cyc, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   // Transaction-level reference: an accepted request is due at +2+DLY and
   // blocks new requests until +3+DLY; reset drops whatever is in flight.
   logic        m_pend = 1'b0;
   int          m_done = 0;
   int          m_free = 0;
   logic [31:0] m_exp  = 32'h0;
   logic [31:0] m_last = 32'h0;
   logic        m_ok, m_dok, m_mis, m_go;
   int          m_n, m_lo;
   logic [3:0]  m_be;

   always @(negedge clk) begin
      if (!areset) begin
         chk("rst_addr_ok", 32'(sl_addr_ok), 32'h0);
         chk("rst_data_ok", 32'(sl_data_ok), 32'h0);
         chk("rst_ram_en",  32'(ram_en),     32'h0);
         chk("rst_ram_we",  32'(ram_we),     32'h0);
         chk("rst_rdata",   sl_rdata,        32'h0);
         m_pend = 1'b0;
         m_free = cyc + 1;
         m_last = 32'h0;
      end else begin
         m_n   = nbytes(sl_size);
         m_lo  = int'(sl_addr[1:0]);
         m_mis = (m_lo % m_n) != 0;
         m_be  = 4'(((1 << m_n) - 1) << ((m_lo / m_n) * m_n));
         m_ok  = (cyc >= m_free) && sl_req;
         m_dok = m_pend && (cyc == m_done);
         m_go  = m_ok && !m_mis;
         chk("addr_ok",   32'(sl_addr_ok), 32'(m_ok));
         chk("data_ok",   32'(sl_data_ok), 32'(m_dok));
         chk("ram_en",    32'(ram_en),     32'(m_go));
         chk("ram_we",    32'(ram_we),     (m_go && sl_wr) ? 32'(m_be) : 32'h0);
         chk("ram_addr",  ram_addr,        m_go ? (sl_addr & ~32'd3) : 32'h0);
         chk("ram_wdata", ram_wdata,       m_go ? sl_wdata : 32'h0);
         if (m_dok) begin
            chk("rdata", sl_rdata, m_exp);
            m_last = m_exp;
            m_pend = 1'b0;
         end else if (cyc >= m_free) begin
            chk("rdata_hold", sl_rdata, m_last);
         end
         if (m_ok) begin
            m_exp = (sl_wr || m_mis) ? 32'h0 : ref_mem[sl_addr[9:2]];
            if (sl_wr && !m_mis)
               for (int b = 0; b < 4; b++)
                  if (m_be[b]) ref_mem[sl_addr[9:2]][8*b +: 8] = sl_wdata[8*b +: 8];
            m_pend = 1'b1;
            m_done = cyc + 2 + DLY;
            m_free = cyc + 3 + DLY;
         end
      end
   end

   // Snapshot of the accept cycle taken by send().
   int          g_cyc;
   logic        g_en;
   logic [3:0]  g_we;
   logic [31:0] g_addr;

   task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
      bit got = 0;
      sl_wr = wr; sl_size = sz; sl_addr = a; sl_wdata = wd; sl_req = 1'b1;
      g_cyc = -100;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         if (sl_addr_ok) begin
            got = 1; g_cyc = cyc; g_en = ram_en; g_we = ram_we; g_addr = ram_addr;
         end
      end
      if (!got) chk("addr_ok_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      sl_req = 1'b0;
   endtask

   task automatic wait_data(output logic [31:0] rd, output int dc);
      bit got = 0;
      rd = 32'h0; dc = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         if (sl_data_ok) begin
            got = 1; rd = sl_rdata; dc = cyc;
         end
      end
      if (!got) chk("data_ok_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, w;
      int dc, t1, t2, cnt;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         ram_mem[i] = w;
         ref_mem[i] = w;
      end
      ram_mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
      ram_mem[8'h80] = 32'h11223344; ref_mem[8'h80] = 32'h11223344;

      repeat (3) @(posedge clk);
      #1 areset = 1'b1;
      @(posedge clk); #1;

      // Word read
      send(1'b0, 2'b10, 32'h100, 32'h0);
      chk("wr_rd_en", 32'(g_en), 32'h1);
      chk("wr_rd_we", 32'(g_we), 32'h0);
      wait_data(rd, dc);
      chk("word_rd_lat", 32'(dc - g_cyc), 32'(2 + DLY));
      chk("word_rd_data", rd, 32'hDEADBEEF);

      // Byte write to top lane, then read back
      send(1'b1, 2'b00, 32'h203, 32'hAB000000);
      chk("bw_we", 32'(g_we), 32'h8);
      chk("bw_addr", g_addr, 32'h200);
      wait_data(rd, dc);
      chk("bw_lat", 32'(dc - g_cyc), 32'(2 + DLY));
      chk("bw_rdata", rd, 32'h0);
      send(1'b0, 2'b10, 32'h200, 32'h0);
      wait_data(rd, dc);
      chk("bw_readback", rd, 32'hAB223344);

      // Upper half write
      send(1'b1, 2'b01, 32'h102, 32'h55660000);
      chk("hw_we", 32'(g_we), 32'hC);
      wait_data(rd, dc);

      // Misaligned word read
      send(1'b0, 2'b10, 32'h102, 32'h0);
      chk("mis_en", 32'(g_en), 32'h0);
      wait_data(rd, dc);
      chk("mis_lat", 32'(dc - g_cyc), 32'(2 + DLY));
      chk("mis_rdata", rd, 32'h0);

      // Back-to-back with sl_req held high
      sl_wr = 1'b0; sl_size = 2'b10; sl_addr = 32'h100; sl_req = 1'b1;
      t1 = -1; t2 = -1;
      for (int i = 0; i < 30 && t2 < 0; i++) begin
         @(negedge clk); #1;
         if (sl_addr_ok) begin
            if (t1 < 0) t1 = cyc; else t2 = cyc;
         end
      end
      @(posedge clk); #1;
      sl_req = 1'b0;
      chk("b2b_gap", 32'(t2 - t1), 32'(3 + DLY));
      repeat (4 + DLY) @(posedge clk);
      #1;

      // Reset while in RAM
      send(1'b0, 2'b10, 32'h100, 32'h0);
      areset = 1'b0;
      @(posedge clk); #1;
      areset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5 + DLY; i++) begin
         @(negedge clk); #1;
         if (sl_data_ok) cnt++;
      end
      chk("rst_abort_no_data_ok", 32'(cnt), 32'h0);
      @(posedge clk); #1;
      send(1'b0, 2'b10, 32'h200, 32'h0);
      wait_data(rd, dc);
      chk("post_rst_lat", 32'(dc - g_cyc), 32'(2 + DLY));
      chk("post_rst_data", rd, 32'hAB223344);

      // Randomized traffic, inputs change every cycle including while busy
      for (int i = 0; i < 3000; i++) begin
         areset   = ($urandom_range(0, 199) != 0);
         sl_req   = ($urandom_range(0, 9) < 7);
         sl_wr    = 1'($urandom_range(0, 1));
         sl_size  = 2'($urandom_range(0, 3));
         sl_addr  = $urandom;
         if (sl_size == 2'b11) sl_addr[1:0] = 2'b00;
         sl_wdata = $urandom;
         @(posedge clk); #1;
      end
      areset = 1'b1;
      sl_req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
